traffic_phase_scheduler: RTL and testbench

//   Demand-driven phase scheduler for a four-approach intersection (N,S,E,W).

---
 rtl/traffic_phase_scheduler_pkg.sv | 24 ++
 rtl/traffic_phase_scheduler_rr_arbiter4.sv | 28 ++
 rtl/traffic_phase_scheduler.sv | 144 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared lamp, direction and state encodings for the four-approach phase scheduler.
// Pure declarations: no logic and no timing.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: first set mask bit strictly after ptr, wrapping to ptr itself.
// Purely combinational, zero latency, no flow control.
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic [1:0] grant_dir,
  output logic       any
);

  logic [1:0] idx;

  // Scan from the lowest priority offset up so the nearest set bit is written last.
  always_comb begin
    grant_dir = DIR_N;
    any       = 1'b0;
    idx       = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) begin
        grant_dir = idx;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin signal controller with min/max green, yellow, all-red and preempt.
// Lamps are Moore-decoded from the registered state; a request is served 2+ cycles after it lands.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TW        = 8,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [2:0] north,
  output logic [2:0] south,
  output logic [2:0] east,
  output logic [2:0] west,
  output logic [1:0] phase_dir,
  output logic       phase_valid,
  output logic       preempt_act
);

  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    pend;
  logic [1:0]    ptr;
  logic [1:0]    cur;

  logic [1:0] arb_dir;
  logic       arb_any;
  logic [3:0] cur_oh;
  logic [3:0] others;
  logic [1:0] next_dir;
  logic       allred_go;
  logic       grant;
  logic       green_norm_exit;
  logic       green_exit;
  logic [3:0] pend_set;
  logic [3:0] pend_clr;
  logic       timer_sat;

  rr_arbiter4 u_arb (
    .mask      (pend),
    .ptr       (ptr),
    .grant_dir (arb_dir),
    .any       (arb_any)
  );

  always_comb begin
    cur_oh    = dir_onehot(cur);
    others    = pend & ~cur_oh;
    next_dir  = preempt ? preempt_dir : arb_dir;
    allred_go = (timer >= T_AR) && (preempt || arb_any);
    grant     = (state == ST_ALL_RED) && allred_go;

    green_norm_exit = (|others) && (timer >= T_GMIN) &&
                      (!req[cur] || (timer >= T_GMAX));
    // A preempt decides the green outright, so a coincident normal exit still yields one yellow.
    green_exit = preempt ? (preempt_dir != cur) : green_norm_exit;

    pend_set  = req & ~((state == ST_GREEN) ? cur_oh : 4'b0000);
    pend_clr  = grant ? dir_onehot(next_dir) : 4'b0000;
    timer_sat = &timer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ALL_RED;
      timer       <= '0;
      pend        <= '0;
      ptr         <= DIR_W;
      cur         <= DIR_N;
      preempt_act <= 1'b0;
    end else begin
      pend  <= (pend | pend_set) & ~pend_clr;
      timer <= timer_sat ? timer : timer + 1'b1;
      case (state)
        ST_ALL_RED: begin
          if (allred_go) begin
            state       <= ST_GREEN;
            timer       <= '0;
            cur         <= next_dir;
            ptr         <= next_dir;
            preempt_act <= preempt;
          end
        end
        ST_GREEN: begin
          if (!preempt) begin
            preempt_act <= 1'b0;
          end
          if (green_exit) begin
            state <= ST_YELLOW;
            timer <= '0;
          end
        end
        ST_YELLOW: begin
          if (timer >= T_YEL) begin
            state <= ST_ALL_RED;
            timer <= '0;
          end
        end
        default: begin
          state <= ST_ALL_RED;
          timer <= '0;
        end
      endcase
    end
  end

  logic [2:0] lamp [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lamp[i] = LAMP_RED;
    end
    if (state == ST_GREEN) begin
      lamp[cur] = LAMP_GRN;
    end else if (state == ST_YELLOW) begin
      lamp[cur] = LAMP_YEL;
    end
  end

  assign north       = lamp[DIR_N];
  assign south       = lamp[DIR_S];
  assign east        = lamp[DIR_E];
  assign west        = lamp[DIR_W];
  assign phase_dir   = cur;
  assign phase_valid = (state == ST_GREEN) || (state == ST_YELLOW);

  a_one_lit: assert property (@(posedge clk)
    $countones({north != LAMP_RED, south != LAMP_RED, east != LAMP_RED, west != LAMP_RED}) <= 1);

  a_legal_state: assert property (@(posedge clk)
    state inside {ST_ALL_RED, ST_GREEN, ST_YELLOW});

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle; a monitor checks them.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;
  localparam int PH_OFF = 0;
  localparam int PH_GRN = 1;
  localparam int PH_YEL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_dir;
  logic [2:0] north, south, east, west;
  logic [1:0] phase_dir;
  logic       phase_valid, preempt_act;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          c;
    logic [15:0] s;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] prev;

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .north       (north),
    .south       (south),
    .east        (east),
    .west        (west),
    .phase_dir   (phase_dir),
    .phase_valid (phase_valid),
    .preempt_act (preempt_act)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected snapshot {N,S,E,W lamps, phase_dir, phase_valid, preempt_act}.
  function automatic logic [15:0] mk(input logic [1:0] d, input int ph, input logic pa);
    logic [2:0] l [4];
    for (int i = 0; i < 4; i++) l[i] = L_R;
    if (ph == PH_GRN) l[d] = L_G;
    if (ph == PH_YEL) l[d] = L_Y;
    return {l[0], l[1], l[2], l[3], d, (ph != PH_OFF), pa};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [15:0] s);
    exp_t e;
    e.c = c;
    e.s = s;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] s;
    exp_t        e;
    if (mon_en) begin
      s = {north, south, east, west, phase_dir, phase_valid, preempt_act};
      check("invariant_one_lit",
            32'($countones({north !== L_R, south !== L_R, east !== L_R, west !== L_R}) <= 1), 32'd1);
      if (s !== prev) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_change: got %h, expected no change from %h (cycle %0d)", s, prev, cyc);
        end else begin
          e = sb.pop_front();
          check("event_cycle", cyc, e.c);
          check("event_outputs", 32'(s), 32'(e.s));
        end
        prev = s;
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; req = 4'b0000; preempt = 1'b0; preempt_dir = 2'd0;

    // 1: reset state, then idle with no demand
    tick(1);
    rst = 1'b0;
    check("rst_north", 32'(north), 32'(L_R));
    check("rst_south", 32'(south), 32'(L_R));
    check("rst_east", 32'(east), 32'(L_R));
    check("rst_west", 32'(west), 32'(L_R));
    check("rst_phase_valid", 32'(phase_valid), 32'd0);
    check("rst_preempt_act", 32'(preempt_act), 32'd0);
    check("rst_phase_dir", 32'(phase_dir), 32'd0);
    prev   = mk(2'd0, PH_OFF, 1'b0);
    mon_en = 1'b1;
    tick(200);

    // 2: single N pulse, N then rests green
    base = cyc;
    req  = 4'b0001;
    tick(1);
    req  = 4'b0000;
    expect_at(base + 2, mk(2'd0, PH_GRN, 1'b0));
    tick(110);

    // 3: N,E,W held from reset -> 38-cycle rotation N,E,W,N
    rst = 1'b1; req = 4'b1101;
    tick(1);
    base = cyc;
    rst  = 1'b0;
    expect_at(base,       mk(2'd0, PH_OFF, 1'b0));
    expect_at(base + 2,   mk(2'd0, PH_GRN, 1'b0));
    expect_at(base + 34,  mk(2'd0, PH_YEL, 1'b0));
    expect_at(base + 38,  mk(2'd0, PH_OFF, 1'b0));
    expect_at(base + 40,  mk(2'd2, PH_GRN, 1'b0));
    expect_at(base + 72,  mk(2'd2, PH_YEL, 1'b0));
    expect_at(base + 76,  mk(2'd2, PH_OFF, 1'b0));
    expect_at(base + 78,  mk(2'd3, PH_GRN, 1'b0));
    expect_at(base + 110, mk(2'd3, PH_YEL, 1'b0));
    expect_at(base + 114, mk(2'd3, PH_OFF, 1'b0));
    expect_at(base + 116, mk(2'd0, PH_GRN, 1'b0));
    tick(120);

    // 4: S granted, S demand drops, E waiting -> S green exactly GREEN_MIN
    rst = 1'b1; req = 4'b0010;
    tick(1);
    base = cyc;
    rst  = 1'b0;
    expect_at(base,      mk(2'd0, PH_OFF, 1'b0));
    expect_at(base + 2,  mk(2'd1, PH_GRN, 1'b0));
    expect_at(base + 10, mk(2'd1, PH_YEL, 1'b0));
    expect_at(base + 14, mk(2'd1, PH_OFF, 1'b0));
    expect_at(base + 16, mk(2'd2, PH_GRN, 1'b0));
    tick(2);
    req = 4'b0100;

    // 5: preempt to W while E green at timer 3, hold, then release
    tick(17);
    preempt = 1'b1; preempt_dir = 2'd3;
    expect_at(base + 20, mk(2'd2, PH_YEL, 1'b0));
    expect_at(base + 24, mk(2'd2, PH_OFF, 1'b0));
    expect_at(base + 26, mk(2'd3, PH_GRN, 1'b1));
    tick(50);
    base    = cyc;
    preempt = 1'b0;
    expect_at(base + 1, mk(2'd3, PH_YEL, 1'b0));
    expect_at(base + 5, mk(2'd3, PH_OFF, 1'b0));
    expect_at(base + 7, mk(2'd2, PH_GRN, 1'b0));

    // 6: reset in mid-yellow clears pending N; a later S request gets served
    tick(30);
    base = cyc;
    req  = 4'b0001;
    tick(1);
    req  = 4'b0000;
    expect_at(base + 2, mk(2'd2, PH_YEL, 1'b0));
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_at(base + 4, mk(2'd0, PH_OFF, 1'b0));
    tick(20);
    base = cyc;
    req  = 4'b0010;
    tick(1);
    req  = 4'b0000;
    expect_at(base + 2, mk(2'd1, PH_GRN, 1'b0));
    tick(10);

    check("pending_expected_events", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
